// File: rtl/btn_debounce_pulse.sv
// Pushbutton conditioner: two-flop synchronizer, debounce FSM, and one-cycle pulse per accepted press.
// Outputs are registered; btn_pulse/btn_level rise DB_COUNT+2 cycles after a clean press.
module btn_debounce_pulse #(
  parameter int DB_COUNT = 500000,
  parameter int CNT_W    = $clog2(DB_COUNT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_pulse,
  output logic btn_level
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam bit               SINGLE   = (DB_COUNT == 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1;
  logic             s;
  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic             pulse_nx;
  logic             level_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1        <= 1'b0;
      s         <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      btn_pulse <= 1'b0;
      btn_level <= 1'b0;
    end else begin
      s1        <= btn_raw;
      s         <= s1;
      state     <= state_nx;
      cnt       <= cnt_nx;
      btn_pulse <= pulse_nx;
      btn_level <= level_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (s) begin
          if (SINGLE) begin
            state_nx = PRESSED;
          end else begin
            state_nx = PRESS_WAIT;
            cnt_nx   = CNT_ONE;
          end
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = PRESSED;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        cnt_nx = '0;
        if (!s) begin
          if (SINGLE) begin
            state_nx = IDLE;
          end else begin
            state_nx = RELEASE_WAIT;
            cnt_nx   = CNT_ONE;
          end
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_nx = PRESSED;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Pulse only on entry into PRESSED from the unpressed side; release never pulses.
  always_comb begin
    pulse_nx = (state_nx == PRESSED) && ((state == IDLE) || (state == PRESS_WAIT));
    level_nx = (state_nx == PRESSED) || (state_nx == RELEASE_WAIT);
  end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Bench for btn_debounce_pulse with DB_COUNT=4: directed scenarios plus random bouncing, checked every cycle
// against a run-length model of the debounce rules.
module tb_btn_debounce_pulse;

  localparam int DB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_raw = 1'b0;
  logic btn_pulse;
  logic btn_level;

  btn_debounce_pulse #(.DB_COUNT(DB)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_pulse(btn_pulse),
    .btn_level(btn_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int npulse   = 0;
  int last_pulse = -1;
  int last_fall  = -1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Model: raw samples reach the debouncer two edges late; the level flips once
  // DB consecutive samples disagree with it, and a pulse marks each flip to 1.
  logic q[$];
  logic m_level = 1'b0;
  logic m_pulse = 1'b0;
  int   m_run   = 0;
  logic prev_pulse = 1'b0;
  logic prev_level = 1'b0;

  initial begin
    q.push_back(1'b0);
    q.push_back(1'b0);
  end

  always @(negedge clk) begin
    logic samp;
    cyc++;
    if (rst) begin
      q.delete();
      q.push_back(1'b0);
      q.push_back(1'b0);
      m_level = 1'b0;
      m_pulse = 1'b0;
      m_run   = 0;
    end else begin
      q.push_back(btn_raw);
      samp    = q.pop_front();
      m_pulse = 1'b0;
      if (samp != m_level) m_run++;
      else m_run = 0;
      if (m_run == DB) begin
        m_level = ~m_level;
        m_run   = 0;
        m_pulse = m_level;
      end
    end
    check("pulse_model", int'(btn_pulse), int'(m_pulse));
    check("level_model", int'(btn_level), int'(m_level));
    check("pulse_single_cycle", int'(prev_pulse && btn_pulse), 0);
    if (btn_pulse) begin
      npulse++;
      last_pulse = cyc;
    end
    if (prev_level && !btn_level) last_fall = cyc;
    prev_pulse = btn_pulse;
    prev_level = btn_level;
  end

  task automatic step(input logic v);
    @(negedge clk);
    #1 btn_raw = v;
  endtask

  task automatic hold(input logic v, input int n);
    for (int i = 0; i < n; i++) step(v);
  endtask

  initial begin
    int t;
    int p0;
    logic pat1 [8];
    logic pat2 [3];
    pat1 = '{1, 1, 0, 1, 1, 1, 0, 0};
    pat2 = '{1, 0, 1};

    // Reset with button held high
    btn_raw = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_pulse", int'(btn_pulse), 0);
    check("reset_level", int'(btn_level), 0);
    p0 = npulse;
    @(negedge clk);
    #1 rst = 1'b0;
    t = cyc;
    hold(1'b1, 12);
    check("rst_hold_count", npulse - p0, 1);
    check("rst_hold_latency", last_pulse - t, 6);
    check("rst_hold_level", int'(btn_level), 1);
    hold(1'b0, 15);
    check("rst_hold_released", int'(btn_level), 0);

    // Clean press
    p0 = npulse;
    step(1'b1);
    t = cyc;
    hold(1'b1, 19);
    check("clean_count", npulse - p0, 1);
    check("clean_latency", last_pulse - t, 6);
    check("clean_level", int'(btn_level), 1);
    hold(1'b0, 15);

    // Bounce rejected
    p0 = npulse;
    for (int i = 0; i < 8; i++) step(pat1[i]);
    hold(1'b0, 12);
    check("bounce_no_pulse", npulse - p0, 0);
    check("bounce_level", int'(btn_level), 0);

    // Bounce then settle high
    p0 = npulse;
    for (int i = 0; i < 3; i++) step(pat2[i]);
    t = cyc;
    hold(1'b1, 10);
    check("settle_count", npulse - p0, 1);
    check("settle_latency", last_pulse - t, 6);

    // Bouncy release: level falls DB+2 cycles after the final falling edge
    hold(1'b1, 5);
    p0 = npulse;
    step(1'b0);
    step(1'b1);
    step(1'b0);
    t = cyc;
    hold(1'b0, 15);
    check("release_no_pulse", npulse - p0, 0);
    check("release_latency", last_fall - t, 6);
    check("release_level", int'(btn_level), 0);

    // Repeated presses
    p0 = npulse;
    for (int k = 0; k < 3; k++) begin
      hold(1'b1, 10);
      hold(1'b0, 10);
    end
    check("repeat_count", npulse - p0, 3);

    // Reset three cycles into a qualification
    p0 = npulse;
    step(1'b1);
    hold(1'b1, 2);
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_no_pulse", npulse - p0, 0);
    #1 rst = 1'b0;
    t = cyc;
    hold(1'b1, 10);
    check("midrst_count", npulse - p0, 1);
    check("midrst_latency", last_pulse - t, 6);
    hold(1'b0, 15);

    // Random bouncing with occasional resets
    for (int k = 0; k < 300; k++) begin
      logic v;
      v = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 40) == 0) begin
        @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
      end
      hold(v, $urandom_range(1, 9));
    end
    hold(1'b0, 15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
